// File: rtl/serial7_receiver_pkg.sv
// Shared state encodings, frame constants and the parity helper for the
// 7-bit serial link receiver.
package serial7_receiver_pkg;

    localparam int DATA_BITS = 7;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    // Returns 1 when the received word and parity bit disagree with the chosen sense.
    function automatic logic parity_bad(input logic [DATA_BITS-1:0] word,
                                        input logic                 par_bit,
                                        input logic                 odd_sense);
        return (^word) ^ par_bit ^ odd_sense;
    endfunction

endpackage

// File: rtl/serial7_receiver_sync_2ff.sv
// Two-flop synchronizer for an asynchronous board input; both flops reset to
// RESET_VAL so an idle-high line never looks like an edge out of reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/serial7_receiver.sv
// Receive end of the 7-bit board serial link: start, 7 data bits LSB first,
// parity, stop. Samples mid-bit and reports word, parity and framing status.
module serial7_receiver
    import serial7_receiver_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter bit ODD_PARITY   = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       LAST_BIT   = 3'(DATA_BITS - 1);

    logic sync_rx;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clock_i (clock),
        .reset_i (reset),
        .d_i     (serial_in),
        .q_o     (sync_rx)
    );

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 sample;

    // The period counter starts at 0 on entry to START, so matching the
    // half-period value lands every sample at mid-bit.
    assign sample = (cnt_q == CNT_SAMPLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!sync_rx) begin
                    state_d   = S_START;
                    bit_idx_d = '0;
                end
            end
            S_START: begin
                if (sample) begin
                    state_d = sync_rx ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (sample) begin
                    shift_d[bit_idx_q] = sync_rx;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = S_PARITY;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (sample) begin
                    par_bit_d = sync_rx;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (sample) begin
                    if (sync_rx) begin
                        state_d    = S_IDLE;
                        valid_d    = 1'b1;
                        data_out_d = shift_q;
                        perr_d     = parity_bad(shift_q, par_bit_q, ODD_PARITY);
                    end else begin
                        state_d = S_WAIT_HIGH;
                        ferr_d  = 1'b1;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (sync_rx) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign data_out      = data_out_q;
    assign data_valid    = valid_q;
    assign parity_error  = perr_q;
    assign framing_error = ferr_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial7_receiver.sv
// Self-checking bench for serial7_receiver: table of frames plus hand-built
// sequences for timing, glitch, back-to-back, held-low line and reset cases.
module tb_serial7_receiver;

    localparam int CPB = 4;

    logic       clk;
    logic       rst;
    logic       serial_e, serial_o;
    logic [6:0] data_e, data_o;
    logic       valid_e, valid_o, perr_e, perr_o, ferr_e, ferr_o, busy_e, busy_o;

    serial7_receiver #(.CLKS_PER_BIT(CPB), .ODD_PARITY(1'b0)) dut (
        .clock         (clk),
        .reset         (rst),
        .serial_in     (serial_e),
        .data_out      (data_e),
        .data_valid    (valid_e),
        .parity_error  (perr_e),
        .framing_error (ferr_e),
        .busy          (busy_e)
    );

    serial7_receiver #(.CLKS_PER_BIT(CPB), .ODD_PARITY(1'b1)) dut_odd (
        .clock         (clk),
        .reset         (rst),
        .serial_in     (serial_o),
        .data_out      (data_o),
        .data_valid    (valid_o),
        .parity_error  (perr_o),
        .framing_error (ferr_o),
        .busy          (busy_o)
    );

    typedef struct {
        logic [6:0] data;
        logic       valid;
        logic       perr;
        logic       ferr;
    } exp_t;

    typedef struct {
        logic [6:0] d;
        logic       p;
        logic       s;
        logic [6:0] exp_data;
        logic       exp_valid;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[9];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_valid_cyc = -1;
    int   prev_valid_cyc = -1;
    logic valid_busy = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
        end
    endtask

    // Scoreboard side: every pulse on the even-parity receiver pops one expectation.
    always @(negedge clk) begin
        if (!rst && (valid_e || perr_e || ferr_e)) begin
            exp_t e;
            if (valid_e) begin
                prev_valid_cyc = last_valid_cyc;
                last_valid_cyc = cyc;
                valid_busy     = busy_e;
            end
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", {valid_e, perr_e, ferr_e}, 0);
            end else begin
                e = sb_q.pop_front();
                check("sb_data_out", data_e, e.data);
                check("sb_data_valid", valid_e, e.valid);
                check("sb_parity_error", perr_e, e.perr);
                check("sb_framing_error", ferr_e, e.ferr);
            end
        end
    end

    task automatic drive_line(input bit odd_sel, input logic b);
        if (odd_sel) serial_o = b;
        else serial_e = b;
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
    endtask

    task automatic send_frame(input bit odd_sel, input logic [6:0] d, input logic p, input logic s);
        logic [9:0] bits;
        bits = {s, p, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            drive_line(odd_sel, bits[i]);
            hold(CPB);
        end
    endtask

    task automatic push_exp(input logic [6:0] d, input logic v, input logic pe, input logic fe);
        exp_t e;
        e.data  = d;
        e.valid = v;
        e.perr  = pe;
        e.ferr  = fe;
        sb_q.push_back(e);
    endtask

    initial begin
        int c;
        logic [6:0] w;

        vecs[0] = '{7'h53, 1'b0, 1'b1, 7'h53, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{7'h53, 1'b1, 1'b1, 7'h53, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{7'h7F, 1'b1, 1'b0, 7'h53, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{7'h00, 1'b0, 1'b1, 7'h00, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{7'h2A, 1'b1, 1'b1, 7'h2A, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{7'h15, 1'b0, 1'b1, 7'h15, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{7'h7F, 1'b1, 1'b1, 7'h7F, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{7'h40, 1'b1, 1'b0, 7'h7F, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{7'h01, 1'b1, 1'b1, 7'h01, 1'b1, 1'b0, 1'b0};

        rst      = 1'b1;
        serial_e = 1'b1;
        serial_o = 1'b1;
        hold(3);
        @(negedge clk);
        check("rst_data_out", data_e, 0);
        check("rst_valid", valid_e, 0);
        check("rst_perr", perr_e, 0);
        check("rst_ferr", ferr_e, 0);
        check("rst_busy", busy_e, 0);
        hold(1);
        rst = 1'b0;
        hold(4);

        // Word 1010011, correct even parity: pulse at t0+39 with receiver idle.
        c = cyc;
        push_exp(7'h53, 1'b1, 1'b0, 1'b0);
        send_frame(1'b0, 7'h53, 1'b0, 1'b1);
        hold(4);
        check("t0_plus_39_valid_cycle", last_valid_cyc, c + 2 + 39);
        check("busy_at_valid", valid_busy, 0);

        for (int i = 0; i < 9; i++) begin
            push_exp(vecs[i].exp_data, vecs[i].exp_valid, vecs[i].exp_perr, vecs[i].exp_ferr);
            send_frame(1'b0, vecs[i].d, vecs[i].p, vecs[i].s);
            drive_line(1'b0, 1'b1);
            hold(6);
        end
        check("table_sb_drained", sb_q.size(), 0);

        // Bad stop bit with the line held low: one framing pulse, no restart.
        push_exp(7'h01, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 7'h7F, 1'b1, 1'b0);
        hold(20);
        check("held_low_busy", busy_e, 1);
        drive_line(1'b0, 1'b1);
        hold(8);
        check("released_busy", busy_e, 0);
        check("held_low_data_kept", data_e, 7'h01);

        // One-cycle glitch: abandoned at the start-bit sample.
        c = cyc;
        drive_line(1'b0, 1'b0);
        hold(1);
        drive_line(1'b0, 1'b1);
        wait_cyc(c + 3);
        check("glitch_busy_in_start", busy_e, 1);
        wait_cyc(c + 6);
        check("glitch_busy_after", busy_e, 0);
        hold(6);

        // Back-to-back frames with no idle bit.
        push_exp(7'h01, 1'b1, 1'b0, 1'b0);
        push_exp(7'h40, 1'b1, 1'b0, 1'b0);
        send_frame(1'b0, 7'h01, 1'b1, 1'b1);
        send_frame(1'b0, 7'h40, 1'b1, 1'b1);
        hold(6);
        check("b2b_spacing", last_valid_cyc - prev_valid_cyc, 40);
        check("b2b_final_data", data_e, 7'h40);

        // Reset during data bit 3, then a clean frame.
        w = 7'h55;
        drive_line(1'b0, 1'b0);
        hold(CPB);
        for (int i = 0; i < 3; i++) begin
            drive_line(1'b0, w[i]);
            hold(CPB);
        end
        drive_line(1'b0, w[3]);
        hold(2);
        check("busy_before_reset", busy_e, 1);
        rst = 1'b1;
        #2;
        check("midrst_data_out", data_e, 0);
        check("midrst_busy", busy_e, 0);
        check("midrst_pulses", {valid_e, perr_e, ferr_e}, 0);
        hold(3);
        drive_line(1'b0, 1'b1);
        rst = 1'b0;
        hold(8);
        push_exp(7'h2A, 1'b1, 1'b0, 1'b0);
        send_frame(1'b0, 7'h2A, 1'b1, 1'b1);
        hold(6);

        // Odd-parity receiver.
        c = cyc;
        send_frame(1'b1, 7'h2A, 1'b0, 1'b1);
        wait_cyc(c + 41);
        check("odd_valid", valid_o, 1);
        check("odd_perr_ok", perr_o, 0);
        check("odd_data", data_o, 7'h2A);
        hold(4);
        c = cyc;
        send_frame(1'b1, 7'h2A, 1'b1, 1'b1);
        wait_cyc(c + 41);
        check("odd_perr_bad", perr_o, 1);
        check("odd_valid_bad", valid_o, 1);
        hold(10);

        check("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
